snake_engine: RTL and testbench
===============================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 16: playfield columns, x in 0..GRID_W-1.
REQ-002 SHALL have parameter GRID_H, default 12: playfield rows, y in 0..GRID_H-1.
REQ-003 SHALL have parameter MAX_LEN, default 32: body capacity in segments, at least 4.
REQ-004 SHALL have parameter GROW_STEP, default 1: segments added per eat event.
REQ-005 SHALL have ports in this order: clk in 1, single clock; rst in 1, synchronous active-high reset; i_tick in 1, move request; i_dir in 2, requested direction; i_eat in 1, eat pulse; o_busy out 1, scan in progress; o_tick_done out 1, scan-complete pulse.
REQ-006 SHALL have ports o_head_x out XW and o_head_y out YW, giving the head position; XW = $clog2(GRID_W) and YW = $clog2(GRID_H).
REQ-007 SHALL have ports o_pos_x out XW, o_pos_y out YW, o_pos_dir out 2, o_pos_first out 1, o_pos_last out 1 and o_pos_valid out 1, forming the segment stream.
REQ-008 SHALL have ports o_length out LW (LW = $clog2(MAX_LEN+1)), o_failure out 1 and o_success out 1.

Function
REQ-009 SHALL use the FSM states IDLE, SCAN, DEAD and WON.
REQ-010 In IDLE, i_tick SHALL advance the head one cell in the effective direction, push that direction at the body front and enter SCAN on the next edge.
REQ-011 An i_dir exactly opposite the current head direction SHALL be ignored; the head SHALL continue in its current direction.
REQ-012 SHALL use direction encoding 0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1).
REQ-013 i_tick in SCAN, DEAD or WON SHALL be ignored; o_busy SHALL be 1 exactly in SCAN.
REQ-014 i_eat in any non-reset cycle SHALL add GROW_STEP to the grow_pending counter, saturating at MAX_LEN.
REQ-015 On each accepted tick with grow_pending>0 and length<MAX_LEN, length SHALL increase by 1 and grow_pending SHALL decrease by 1; otherwise the tail segment is dropped.
REQ-016 In SCAN, SHALL emit one segment per clock, index 0 (head) to length-1, with o_pos_valid=1, o_pos_first at index 0 and o_pos_last at index length-1.
REQ-017 SHALL set o_pos_dir to the stored direction of that segment.
REQ-018 SHALL set o_failure, enter DEAD and terminate the scan when a segment with index>0 equals the head.
REQ-019 SHALL pulse o_tick_done for 1 cycle in the cycle after o_pos_last, then enter IDLE, or WON if length==MAX_LEN (o_success=1).
REQ-020 Without wrap, a head move outside the grid SHALL enter DEAD on the tick edge, with no scan and no o_tick_done.
REQ-021 DEAD and WON SHALL be sticky until rst; o_pos_valid SHALL be 0 outside SCAN.

Reset
REQ-022 On rst, the engine SHALL set head=(GRID_W/2, GRID_H/2), head direction 3, length 1, grow_pending 0 and state IDLE.
REQ-023 On rst, all outputs other than o_head_x, o_head_y and o_length SHALL be 0.
REQ-024 rst asserted mid-SCAN SHALL abort the scan with no o_tick_done pulse.

Configuration
REQ-025 With macro SNAKE_WRAP_EN defined, head moves SHALL wrap toroidally (x=GRID_W-1 moving right goes to 0, x=0 moving left goes to GRID_W-1, and likewise for y), and walls SHALL never cause DEAD.
REQ-026 Without SNAKE_WRAP_EN, wall behaviour SHALL follow REQ-020.

Structure
REQ-027 Package snake_pkg SHALL hold the dir_t enum, the state_t enum and the function opposite(dir_t).
REQ-028 Sub-module dir_shiftreg, parametrised WIDTH=2 and DEPTH=MAX_LEN, SHALL hold the body directions, with push-front, a read port indexed by scan position and a synchronous clear on rst.

Verification (GRID_W=16, GRID_H=12, MAX_LEN=32, GROW_STEP=1)
REQ-029 Test: after reset, one tick with i_dir=3 -> head=(9,6), exactly 1 segment at (9,6) with first=last=1, and o_tick_done 1 cycle later.
REQ-030 Test: head direction 3 and i_dir=2 on tick -> the request is ignored and head x increments.
REQ-031 Test: eat, then 3 ticks -> o_length=2, and the scan emits 2 segments, last at the previous head cell.
REQ-032 Test: grow to length 5 and steer up, left, down -> self-hit at index 4, o_failure=1, state DEAD, and further ticks are ignored.
REQ-033 Test: run right from x=15 -> DEAD without wrap; x=0 with SNAKE_WRAP_EN.
REQ-034 Test: assert rst mid-SCAN at index 2 -> no o_tick_done, outputs at reset values next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake engine: movement directions, FSM states and
// the reverse-direction helper.
package snake_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DEAD,
        WON
    } state_t;

    // Up/down and left/right differ only in bit 0.
    function automatic dir_t opposite(dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/dir_shiftreg.sv
// Body direction store: push-front shift register with an indexed read port
// and a synchronous clear.
module dir_shiftreg #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[0] <= push_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: head movement, growth and a per-tick segment scan with
// self-collision detection. Define SNAKE_WRAP_EN for a toroidal playfield.
module snake_engine
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = 16,
    parameter int unsigned GRID_H    = 12,
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned GROW_STEP = 1,
    localparam int unsigned XW = $clog2(GRID_W),
    localparam int unsigned YW = $clog2(GRID_H),
    localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic [1:0]    i_dir,
    input  logic          i_eat,
    output logic          o_busy,
    output logic          o_tick_done,
    output logic [XW-1:0] o_head_x,
    output logic [YW-1:0] o_head_y,
    output logic [XW-1:0] o_pos_x,
    output logic [YW-1:0] o_pos_y,
    output logic [1:0]    o_pos_dir,
    output logic          o_pos_first,
    output logic          o_pos_last,
    output logic          o_pos_valid,
    output logic [LW-1:0] o_length,
    output logic          o_failure,
    output logic          o_success
);

    localparam int unsigned IW = $clog2(MAX_LEN);

    state_t          state;
    dir_t            head_dir;
    logic [LW-1:0]   grow_pending;
    logic [LW-1:0]   grow_pending_d;
    logic [LW-1:0]   idx;
    dir_t            req_dir;
    dir_t            eff_dir;
    int              nx, ny, sx, sy, gp;
    logic            wall_hit;
    logic            grow;
    logic            accept;
    logic            hit;
    logic [1:0]      rd_data;

    assign o_busy = (state == SCAN);
    assign grow   = (grow_pending != '0) && (o_length < LW'(MAX_LEN));
    assign accept = (state == IDLE) && i_tick && !wall_hit;
    assign hit    = (idx != '0) && (o_pos_x == o_head_x) && (o_pos_y == o_head_y);

    // Candidate head cell for the effective direction.
    always_comb begin
        req_dir  = dir_t'(i_dir);
        eff_dir  = (req_dir == opposite(head_dir)) ? head_dir : req_dir;
        nx       = int'(o_head_x);
        ny       = int'(o_head_y);
        wall_hit = 1'b0;
        case (eff_dir)
            DirUp:   ny = ny - 1;
            DirDown: ny = ny + 1;
            DirLeft: nx = nx - 1;
            default: nx = nx + 1;
        endcase
`ifdef SNAKE_WRAP_EN
        if (nx < 0) nx = int'(GRID_W) - 1;
        if (nx >= int'(GRID_W)) nx = 0;
        if (ny < 0) ny = int'(GRID_H) - 1;
        if (ny >= int'(GRID_H)) ny = 0;
`else
        wall_hit = (nx < 0) || (nx >= int'(GRID_W)) || (ny < 0) || (ny >= int'(GRID_H));
`endif
    end

    // Next segment lies one step behind the current one, against its direction.
    always_comb begin
        sx = int'(o_pos_x);
        sy = int'(o_pos_y);
        case (dir_t'(o_pos_dir))
            DirUp:   sy = sy + 1;
            DirDown: sy = sy - 1;
            DirLeft: sx = sx + 1;
            default: sx = sx - 1;
        endcase
        if (sx < 0) sx = int'(GRID_W) - 1;
        if (sx >= int'(GRID_W)) sx = 0;
        if (sy < 0) sy = int'(GRID_H) - 1;
        if (sy >= int'(GRID_H)) sy = 0;
    end

    always_comb begin
        gp = int'(grow_pending);
        if (accept && grow) gp = gp - 1;
        if (i_eat) gp = gp + int'(GROW_STEP);
        if (gp > int'(MAX_LEN)) gp = int'(MAX_LEN);
        grow_pending_d = LW'(gp);
    end

    dir_shiftreg #(
        .WIDTH (2),
        .DEPTH (MAX_LEN)
    ) u_dirs (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (eff_dir),
        .rd_idx    (IW'(idx + LW'(1))),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            head_dir     <= DirRight;
            o_head_x     <= XW'(GRID_W / 2);
            o_head_y     <= YW'(GRID_H / 2);
            o_length     <= LW'(1);
            grow_pending <= '0;
            idx          <= '0;
            o_pos_x      <= '0;
            o_pos_y      <= '0;
            o_pos_dir    <= '0;
            o_pos_first  <= 1'b0;
            o_pos_last   <= 1'b0;
            o_pos_valid  <= 1'b0;
            o_tick_done  <= 1'b0;
            o_failure    <= 1'b0;
            o_success    <= 1'b0;
        end else begin
            o_tick_done  <= 1'b0;
            grow_pending <= grow_pending_d;
            case (state)
                IDLE: begin
                    if (i_tick && wall_hit) begin
                        state     <= DEAD;
                        o_failure <= 1'b1;
                    end else if (accept) begin
                        state       <= SCAN;
                        head_dir    <= eff_dir;
                        o_head_x    <= XW'(nx);
                        o_head_y    <= YW'(ny);
                        idx         <= '0;
                        o_pos_valid <= 1'b1;
                        o_pos_x     <= XW'(nx);
                        o_pos_y     <= YW'(ny);
                        o_pos_dir   <= eff_dir;
                        o_pos_first <= 1'b1;
                        o_pos_last  <= !grow && (o_length == LW'(1));
                        if (grow) o_length <= o_length + LW'(1);
                    end
                end
                SCAN: begin
                    if (hit) begin
                        state       <= DEAD;
                        o_failure   <= 1'b1;
                        o_pos_valid <= 1'b0;
                        o_pos_first <= 1'b0;
                        o_pos_last  <= 1'b0;
                    end else if (o_pos_last) begin
                        o_pos_valid <= 1'b0;
                        o_pos_first <= 1'b0;
                        o_pos_last  <= 1'b0;
                        o_tick_done <= 1'b1;
                        if (o_length == LW'(MAX_LEN)) begin
                            state     <= WON;
                            o_success <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        idx         <= idx + LW'(1);
                        o_pos_x     <= XW'(sx);
                        o_pos_y     <= YW'(sy);
                        o_pos_dir   <= rd_data;
                        o_pos_first <= 1'b0;
                        o_pos_last  <= (idx + LW'(2)) == o_length;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: a position-list model queues expected
// segments, a negedge monitor pops and compares them. Honours SNAKE_WRAP_EN.
module tb_snake_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_tick = 1'b0;
    logic [1:0] i_dir = 2'd3;
    logic       i_eat = 1'b0;
    logic       o_busy, o_tick_done, o_pos_first, o_pos_last, o_pos_valid;
    logic       o_failure, o_success;
    logic [3:0] o_head_x, o_head_y, o_pos_x, o_pos_y;
    logic [1:0] o_pos_dir;
    logic [5:0] o_length;

    snake_engine #(
        .GRID_W    (16),
        .GRID_H    (12),
        .MAX_LEN   (32),
        .GROW_STEP (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (i_tick),
        .i_dir       (i_dir),
        .i_eat       (i_eat),
        .o_busy      (o_busy),
        .o_tick_done (o_tick_done),
        .o_head_x    (o_head_x),
        .o_head_y    (o_head_y),
        .o_pos_x     (o_pos_x),
        .o_pos_y     (o_pos_y),
        .o_pos_dir   (o_pos_dir),
        .o_pos_first (o_pos_first),
        .o_pos_last  (o_pos_last),
        .o_pos_valid (o_pos_valid),
        .o_length    (o_length),
        .o_failure   (o_failure),
        .o_success   (o_success)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
        bit first;
        bit last;
        bit hit;
    } seg_t;

    seg_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference model: explicit list of body cells, head first.
    int   bx[$];
    int   by[$];
    int   bd[$];
    int   m_hx, m_hy, m_hd, m_len, m_gp;
    bit   m_dead;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        bx.delete(); by.delete(); bd.delete(); sb.delete();
        bx.push_back(8); by.push_back(6); bd.push_back(0);
        m_hx = 8; m_hy = 6; m_hd = 3; m_len = 1; m_gp = 0; m_dead = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_head_x", int'(o_head_x), 8);
        chk("rst_head_y", int'(o_head_y), 6);
        chk("rst_length", int'(o_length), 1);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_valid", int'(o_pos_valid), 0);
        chk("rst_tick_done", int'(o_tick_done), 0);
        chk("rst_failure", int'(o_failure), 0);
        chk("rst_success", int'(o_success), 0);
        chk("rst_pos_x", int'(o_pos_x), 0);
        chk("rst_pos_first_last", int'({o_pos_first, o_pos_last}), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_reset_outputs();
    endtask

    task automatic do_eat();
        @(posedge clk); #1;
        i_eat = 1'b1;
        @(posedge clk); #1;
        i_eat = 1'b0;
        m_gp = (m_gp + 1 > 32) ? 32 : m_gp + 1;
    endtask

    // abort_at >= 0: assert rst while segment abort_at is on the stream.
    task automatic do_tick(input int d, input int abort_at);
        int  nx, ny, ed, cnt, lim;
        bit  wall;
        ed = d;
        if ((d ^ 1) == m_hd) ed = m_hd;
        nx = m_hx;
        ny = m_hy;
        case (ed)
            0:       ny = ny - 1;
            1:       ny = ny + 1;
            2:       nx = nx - 1;
            default: nx = nx + 1;
        endcase
        wall = 0;
`ifdef SNAKE_WRAP_EN
        nx = (nx + 16) % 16;
        ny = (ny + 12) % 12;
`else
        wall = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 11);
`endif
        if (!m_dead) begin
            if (wall) begin
                m_dead = 1;
            end else begin
                m_hx = nx; m_hy = ny; m_hd = ed;
                bx.push_front(nx); by.push_front(ny); bd.push_front(ed);
                if (m_gp > 0 && m_len < 32) begin
                    m_len++;
                    m_gp--;
                end else begin
                    void'(bx.pop_back()); void'(by.pop_back()); void'(bd.pop_back());
                end
                lim = (abort_at >= 0) ? abort_at + 1 : m_len;
                for (int i = 0; i < lim; i++) begin
                    seg_t s;
                    s.x = bx[i]; s.y = by[i]; s.d = bd[i];
                    s.first = (i == 0);
                    s.last = (i == m_len - 1);
                    s.hit = (i > 0) && (bx[i] == m_hx) && (by[i] == m_hy);
                    sb.push_back(s);
                    if (s.hit) begin
                        m_dead = 1;
                        break;
                    end
                end
            end
        end
        @(posedge clk); #1;
        i_tick = 1'b1;
        i_dir = 2'(d);
        @(posedge clk); #1;
        i_tick = 1'b0;
        if (abort_at >= 0) begin
            repeat (abort_at) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_reset_outputs();
            chk("abort_sb_empty", sb.size(), 0);
            model_reset();
            return;
        end
        cnt = 0;
        while (o_busy && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL scan_timeout: busy still %0d after %0d cycles", o_busy, cnt);
        end
        chk("head_x", int'(o_head_x), m_hx);
        chk("head_y", int'(o_head_y), m_hy);
        chk("length", int'(o_length), m_len);
        chk("failure", int'(o_failure), int'(m_dead));
        chk("sb_drained", sb.size(), 0);
    endtask

    // Monitor: compare every streamed segment and the follow-up pulses.
    initial begin
        bit   pend_done;
        bit   pend_hit;
        seg_t e;
        pend_done = 0;
        pend_hit = 0;
        forever begin
            @(negedge clk);
            if (pend_done || o_tick_done) chk("tick_done", int'(o_tick_done), int'(pend_done));
            if (pend_hit) chk("failure_after_hit", int'(o_failure), 1);
            pend_done = 0;
            pend_hit = 0;
            if (o_pos_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_segment: got (%0d,%0d), expected none",
                             o_pos_x, o_pos_y);
                end else begin
                    e = sb.pop_front();
                    chk("seg_x", int'(o_pos_x), e.x);
                    chk("seg_y", int'(o_pos_y), e.y);
                    chk("seg_dir", int'(o_pos_dir), e.d);
                    chk("seg_first", int'(o_pos_first), int'(e.first));
                    chk("seg_last", int'(o_pos_last), int'(e.last));
                    pend_done = e.last && !e.hit;
                    pend_hit = e.hit;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        // Single move, then an ignored reversal.
        do_tick(3, -1);
        do_tick(2, -1);
        // Eat then three ticks: length 2.
        do_eat();
        do_tick(3, -1);
        do_tick(3, -1);
        do_tick(3, -1);

        // Grow to 5 and hook back into the body.
        do_reset();
        repeat (4) do_eat();
        repeat (4) do_tick(3, -1);
        do_tick(0, -1);
        do_tick(2, -1);
        do_tick(1, -1);
        chk("dead_busy", int'(o_busy), 0);
        do_tick(0, -1);
        chk("dead_sticky", int'(o_failure), 1);

        // Abort a scan with rst while index 2 is streaming.
        do_reset();
        repeat (3) do_eat();
        repeat (3) do_tick(3, -1);
        do_tick(3, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("post_abort_valid", int'(o_pos_valid), 0);

        // Right-hand wall from x=15.
        do_reset();
        repeat (8) do_tick(3, -1);
`ifdef SNAKE_WRAP_EN
        chk("wrap_x", int'(o_head_x), 0);
`else
        chk("wall_dead", int'(o_failure), 1);
        do_tick(0, -1);
`endif
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
